// File: rtl/vreg_wb_collector_pkg.sv
// Shared definitions for the vector write-back collector.
//   - Element-word layout: {valid, mask_bit, data}. Valid sits directly above
//     the mask bit, which sits directly above the data field.
//   - clog2 helper, used to size index fields.
//   - FSM state encoding.
package vreg_wb_collector_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int VALID_BIT      = DEF_DATA_WIDTH + 1;
    localparam int MASK_BIT       = DEF_DATA_WIDTH;
    localparam int ELEM_W         = DEF_DATA_WIDTH + 2;

    // Field positions for an arbitrary data width.
    function automatic int valid_pos(input int dw);
        return dw + 1;
    endfunction

    function automatic int mask_pos(input int dw);
        return dw;
    endfunction

    function automatic int elem_width(input int dw);
        return dw + 2;
    endfunction

    // Smallest number of bits r with 2**r >= n. Both 0 and 1 give 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FINISH  = 2'd2
    } state_t;

endpackage

// File: rtl/vreg_wb_collector.sv
// vreg_wb_collector: write-back end of the vector functional-unit stream.
// Each accepted element {valid, mask_bit, data} is written to the vector
// register file at (vd, element index). Masked-off elements still consume
// an index. done pulses once VLR elements have been retired.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse; latches vd, VLR and masked
//   vd                destination vector register
//   VLR               number of elements to retire (clamped to MVL)
//   masked            1: mask_bit gates the write; 0: write every element
//   in_elem           stream word {valid, mask_bit, data}
//   we                register-file write enable (registered)
//   waddr_reg         write register index
//   waddr_elem        write element index
//   wdata             write data
//   busy              collection in progress
//   done              one-cycle completion pulse
//   overrun           sticky: a valid element arrived while not collecting
//   retired           elements consumed in the current or last operation
module vreg_wb_collector
    import vreg_wb_collector_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MVL        = 16,
    parameter int NREGS      = 32,
    parameter int VLR_W      = clog2(MVL + 1),
    parameter int IDX_W      = clog2(MVL),
    parameter int REG_W      = clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [REG_W-1:0]      vd,
    input  logic [VLR_W-1:0]      VLR,
    input  logic                  masked,
    input  logic [DATA_WIDTH+1:0] in_elem,
    output logic                  we,
    output logic [REG_W-1:0]      waddr_reg,
    output logic [IDX_W-1:0]      waddr_elem,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [VLR_W-1:0]      retired
);

    localparam int VBIT = valid_pos(DATA_WIDTH);
    localparam int MBIT = mask_pos(DATA_WIDTH);
    localparam logic [VLR_W-1:0] MVL_V = VLR_W'(MVL);

    state_t                  state;
    logic [REG_W-1:0]        vd_reg;
    logic [VLR_W-1:0]        vlr_reg;
    logic                    masked_reg;
    logic [IDX_W-1:0]        cnt;

    logic                    elem_vld;
    logic                    elem_mask;
    logic [DATA_WIDTH-1:0]   elem_data;
    logic                    last_elem;

    // A VLR above MVL would index past the register; limit it to MVL.
    function automatic logic [VLR_W-1:0] clamp_vlr(input logic [VLR_W-1:0] v);
        return (v > MVL_V) ? MVL_V : v;
    endfunction

    assign elem_vld  = in_elem[VBIT];
    assign elem_mask = in_elem[MBIT];
    assign elem_data = in_elem[DATA_WIDTH-1:0];

    // COLLECT is only entered with vlr_reg >= 1, so the subtraction never
    // underflows while this signal is in use.
    assign last_elem = (VLR_W'(cnt) == (vlr_reg - VLR_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            vd_reg     <= '0;
            vlr_reg    <= '0;
            masked_reg <= 1'b0;
            cnt        <= '0;
            we         <= 1'b0;
            waddr_reg  <= '0;
            waddr_elem <= '0;
            wdata      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overrun    <= 1'b0;
            retired    <= '0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        vd_reg     <= vd;
                        vlr_reg    <= clamp_vlr(VLR);
                        masked_reg <= masked;
                        cnt        <= '0;
                        retired    <= '0;
                        overrun    <= 1'b0;
                        if (VLR == '0) begin
                            // Nothing to collect: done appears on the next cycle.
                            state <= S_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_COLLECT;
                            busy  <= 1'b1;
                        end
                    end else if (elem_vld) begin
                        overrun <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (elem_vld) begin
                        // A masked-off element still takes its index, so
                        // later elements keep their positions.
                        we         <= ~masked_reg | elem_mask;
                        waddr_reg  <= vd_reg;
                        waddr_elem <= cnt;
                        wdata      <= elem_data;
                        if (retired != vlr_reg) begin
                            retired <= retired + VLR_W'(1);
                        end
                        if (last_elem) begin
                            // done lines up with the write of the last element.
                            state <= S_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                    if (elem_vld) begin
                        overrun <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vreg_wb_collector.sv
module tb_vreg_wb_collector;

    logic        clk;
    logic        rst;
    logic        start;
    logic [4:0]  vd;
    logic [4:0]  vlr;
    logic        masked;
    logic [33:0] in_elem;
    logic        we;
    logic [4:0]  waddr_reg;
    logic [3:0]  waddr_elem;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        overrun;
    logic [4:0]  retired;

    vreg_wb_collector dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .vd         (vd),
        .VLR        (vlr),
        .masked     (masked),
        .in_elem    (in_elem),
        .we         (we),
        .waddr_reg  (waddr_reg),
        .waddr_elem (waddr_elem),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [3:0]  e;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;

    int checks = 0;
    int errors = 0;

    // Reference model of the collection in progress.
    bit         collecting = 0;
    bit         cur_masked = 0;
    logic [4:0] cur_vd     = '0;
    int         cur_len    = 0;
    int         idx        = 0;

    task automatic start_op(input logic [4:0] d_vd, input logic [4:0] d_vlr, input bit d_masked);
        @(negedge clk);
        rst        = 1'b0;
        start      = 1'b1;
        vd         = d_vd;
        vlr        = d_vlr;
        masked     = d_masked;
        in_elem    = '0;
        cur_vd     = d_vd;
        cur_masked = d_masked;
        cur_len    = (int'(d_vlr) > 16) ? 16 : int'(d_vlr);
        idx        = 0;
        collecting = (cur_len != 0);
        @(posedge clk);
        #1;
    endtask

    // Drives one stream word and records the write it should produce.
    task automatic drive(input bit v, input bit m, input logic [31:0] d);
        @(negedge clk);
        rst     = 1'b0;
        start   = 1'b0;
        in_elem = {v, m, d};
        if (collecting && v) begin
            if (!cur_masked || m) exp_q.push_back('{cur_vd, idx[3:0], d});
            idx = idx + 1;
            if (idx == cur_len) collecting = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; vd = '0; vlr = '0; masked = 1'b0; in_elem = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({we, done, busy, overrun, retired, waddr_reg, waddr_elem, wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b done=%b busy=%b ovr=%b ret=%0d reg=%0d elem=%0d data=%h required all 0",
                     we, done, busy, overrun, retired, waddr_reg, waddr_elem, wdata);
        end
    endtask

    task automatic test_basic();
        start_op(5'd3, 5'd4, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || retired !== 5'd0) begin
            errors++;
            $display("FAIL basic_start: got busy=%b done=%b ret=%0d required busy=1 done=0 ret=0", busy, done, retired);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 32'h11 + i);
            checks++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL basic_wr: got unexpected we=1 elem=%0d required we=0", waddr_elem);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr_reg, waddr_elem, wdata} !== {e.r, e.e, e.d}) begin
                        errors++;
                        $display("FAIL basic_wr: got reg=%0d elem=%0d data=%h required reg=%0d elem=%0d data=%h",
                                 waddr_reg, waddr_elem, wdata, e.r, e.e, e.d);
                    end
                end
            end else if (exp_q.size() != 0) begin
                errors++; $display("FAIL basic_wr: got we=0 required we=1 elem=%0d", exp_q[0].e); exp_q.delete();
            end
            checks++;
            if (done !== (i == 3)) begin
                errors++; $display("FAIL basic_done: cycle %0d got done=%b required %b", i, done, (i == 3));
            end
        end
        checks++;
        if (busy !== 1'b0 || retired !== 5'd4) begin
            errors++; $display("FAIL basic_end: got busy=%b ret=%0d required busy=0 ret=4", busy, retired);
        end
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got done=%b required 0", done);
        end
    endtask

    task automatic test_masked();
        bit mb[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        start_op(5'd5, 5'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mb[i], 32'hA0 + i);
            checks++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL masked_wr: got unexpected we=1 elem=%0d required we=0", waddr_elem);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr_reg, waddr_elem, wdata} !== {e.r, e.e, e.d}) begin
                        errors++;
                        $display("FAIL masked_wr: got reg=%0d elem=%0d data=%h required reg=%0d elem=%0d data=%h",
                                 waddr_reg, waddr_elem, wdata, e.r, e.e, e.d);
                    end
                end
            end else if (exp_q.size() != 0) begin
                errors++; $display("FAIL masked_wr: got we=0 required we=1 elem=%0d", exp_q[0].e); exp_q.delete();
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || retired !== 5'd4) begin
            errors++; $display("FAIL masked_end: got done=%b busy=%b ret=%0d required done=1 busy=0 ret=4", done, busy, retired);
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_bubbles();
        bit vp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        start_op(5'd9, 5'd3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(vp[i], 1'b0, 32'h300 + i);
            checks++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL bubble_wr: got unexpected we=1 elem=%0d required we=0", waddr_elem);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr_reg, waddr_elem, wdata} !== {e.r, e.e, e.d}) begin
                        errors++;
                        $display("FAIL bubble_wr: got reg=%0d elem=%0d data=%h required reg=%0d elem=%0d data=%h",
                                 waddr_reg, waddr_elem, wdata, e.r, e.e, e.d);
                    end
                end
            end else if (exp_q.size() != 0) begin
                errors++; $display("FAIL bubble_wr: got we=0 required we=1 elem=%0d", exp_q[0].e); exp_q.delete();
            end
            checks++;
            if (busy !== (i < 5) || done !== (i == 5)) begin
                errors++; $display("FAIL bubble_ctl: cycle %0d got busy=%b done=%b required busy=%b done=%b",
                                   i, busy, done, (i < 5), (i == 5));
            end
        end
        checks++;
        if (retired !== 5'd3) begin
            errors++; $display("FAIL bubble_ret: got %0d required 3", retired);
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_vlr_zero();
        start_op(5'd2, 5'd0, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || we !== 1'b0) begin
            errors++; $display("FAIL vlr0_done: got done=%b busy=%b we=%b required done=1 busy=0 we=0", done, busy, we);
        end
        drive(1'b0, 1'b0, 32'h0);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || we !== 1'b0) begin
            errors++; $display("FAIL vlr0_after: got done=%b busy=%b we=%b required all 0", done, busy, we);
        end
    endtask

    task automatic test_overrun();
        drive(1'b1, 1'b1, 32'hDEAD);
        checks++;
        if (overrun !== 1'b1 || we !== 1'b0) begin
            errors++; $display("FAIL ovr_idle: got overrun=%b we=%b required overrun=1 we=0", overrun, we);
        end
        start_op(5'd4, 5'd1, 1'b0);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL ovr_clear: got overrun=%b busy=%b required overrun=0 busy=1", overrun, busy);
        end
        drive(1'b1, 1'b0, 32'h55);
        checks++;
        if (we !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL ovr_wr: got we=%b queued=%0d required we=1 queued=1", we, exp_q.size());
            exp_q.delete();
        end else begin
            e = exp_q.pop_front();
            if ({waddr_reg, waddr_elem, wdata, done} !== {e.r, e.e, e.d, 1'b1}) begin
                errors++;
                $display("FAIL ovr_wr: got reg=%0d elem=%0d data=%h done=%b required reg=%0d elem=%0d data=%h done=1",
                         waddr_reg, waddr_elem, wdata, done, e.r, e.e, e.d);
            end
        end
        // Valid element during the FINISH cycle.
        drive(1'b1, 1'b0, 32'h66);
        checks++;
        if (overrun !== 1'b1 || we !== 1'b0) begin
            errors++; $display("FAIL ovr_finish: got overrun=%b we=%b required overrun=1 we=0", overrun, we);
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_clamp();
        start_op(5'd6, 5'd20, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 32'h1000 + i * 3);
            checks++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL clamp_wr: got unexpected we=1 elem=%0d required we=0", waddr_elem);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr_reg, waddr_elem, wdata} !== {e.r, e.e, e.d}) begin
                        errors++;
                        $display("FAIL clamp_wr: got reg=%0d elem=%0d data=%h required reg=%0d elem=%0d data=%h",
                                 waddr_reg, waddr_elem, wdata, e.r, e.e, e.d);
                    end
                end
            end else if (exp_q.size() != 0) begin
                errors++; $display("FAIL clamp_wr: got we=0 required we=1 elem=%0d", exp_q[0].e); exp_q.delete();
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || retired !== 5'd16) begin
            errors++; $display("FAIL clamp_end: got done=%b busy=%b ret=%0d required done=1 busy=0 ret=16", done, busy, retired);
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid();
        start_op(5'd7, 5'd8, 1'b0);
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin
                // Reset lands with a valid element on the input.
                @(negedge clk);
                rst = 1'b1;
                in_elem = {1'b1, 1'b0, 32'hBAD0};
                collecting = 0;
                exp_q.delete();
                @(posedge clk);
                #1;
                checks++;
                if ({we, done, busy, overrun, retired, waddr_reg, waddr_elem, wdata} !== '0) begin
                    errors++;
                    $display("FAIL rst_mid: got we=%b done=%b busy=%b ovr=%b ret=%0d reg=%0d elem=%0d data=%h required all 0",
                             we, done, busy, overrun, retired, waddr_reg, waddr_elem, wdata);
                end
            end else begin
                drive(1'b1, 1'b0, 32'h700 + i);
                checks++;
                if (we) begin
                    if (exp_q.size() == 0) begin
                        errors++; $display("FAIL rst_wr: got unexpected we=1 elem=%0d required we=0", waddr_elem);
                    end else begin
                        e = exp_q.pop_front();
                        if ({waddr_reg, waddr_elem, wdata} !== {e.r, e.e, e.d}) begin
                            errors++;
                            $display("FAIL rst_wr: got reg=%0d elem=%0d data=%h required reg=%0d elem=%0d data=%h",
                                     waddr_reg, waddr_elem, wdata, e.r, e.e, e.d);
                        end
                    end
                end else if (exp_q.size() != 0) begin
                    errors++; $display("FAIL rst_wr: got we=0 required we=1 elem=%0d", exp_q[0].e); exp_q.delete();
                end
            end
        end
        start_op(5'd1, 5'd2, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h900 + i);
            checks++;
            if (we) begin
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rst_new_wr: got unexpected we=1 elem=%0d required we=0", waddr_elem);
                end else begin
                    e = exp_q.pop_front();
                    if ({waddr_reg, waddr_elem, wdata} !== {e.r, e.e, e.d}) begin
                        errors++;
                        $display("FAIL rst_new_wr: got reg=%0d elem=%0d data=%h required reg=%0d elem=%0d data=%h",
                                 waddr_reg, waddr_elem, wdata, e.r, e.e, e.d);
                    end
                end
            end else if (exp_q.size() != 0) begin
                errors++; $display("FAIL rst_new_wr: got we=0 required we=1 elem=%0d", exp_q[0].e); exp_q.delete();
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || retired !== 5'd2) begin
            errors++; $display("FAIL rst_new_end: got done=%b busy=%b ret=%0d required done=1 busy=0 ret=2", done, busy, retired);
        end
        drive(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_masked();
        test_bubbles();
        test_vlr_zero();
        test_overrun();
        test_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
